// File: rtl/trunc_mul_seq_pkg.sv
// Shared types and width helpers for the truncated-multiply sequencer.
package trunc_mul_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StArm,
    StRdA,
    StRdB,
    StNorm,
    StMul,
    StDenorm,
    StWr,
    StDone
  } state_e;

  // Bits needed to hold n distinct values, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lead_one_norm.sv
// Leading-one normaliser: shifts a loaded operand left until its MSB is set or the
// shift count saturates, exposing the top KEEP_BITS as the truncated operand.
module lead_one_norm
  import trunc_mul_seq_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned KEEP_BITS = 8,
  localparam int unsigned SMAX     = DATA_W - KEEP_BITS,
  localparam int unsigned SH_W     = cnt_width(SMAX + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 en,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    value,
  output logic [KEEP_BITS-1:0] trunc,
  output logic [SH_W-1:0]      sh,
  output logic                 moving
);

  logic [DATA_W-1:0] value_q;
  logic [SH_W-1:0]   sh_q;

  // A zero operand keeps shifting until the counter saturates at SMAX.
  assign moving = en & ~value_q[DATA_W-1] & (sh_q < SH_W'(SMAX));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      sh_q    <= '0;
    end else if (load) begin
      value_q <= din;
      sh_q    <= '0;
    end else if (moving) begin
      value_q <= value_q << 1;
      sh_q    <= sh_q + SH_W'(1);
    end
  end

  assign value = value_q;
  assign trunc = value_q[DATA_W-1 -: KEEP_BITS];
  assign sh    = sh_q;

endmodule

// File: rtl/trunc_mul_seq.sv
// Sequencer and datapath for truncated (or exact) multiplication of operand pairs
// read from RAM, with results written back starting at WR_BASE.
module trunc_mul_seq
  import trunc_mul_seq_pkg::*;
#(
  parameter int unsigned        DATA_W    = 16,
  parameter int unsigned        KEEP_BITS = 8,
  parameter int unsigned        NUM_PAIRS = 8,
  parameter int unsigned        ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]  WR_BASE   = 'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_exact,
  input  logic                  abort,
  output logic                  mem_rd_req,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic                  mem_rd_valid,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [2*DATA_W-1:0]   mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned SMAX  = DATA_W - KEEP_BITS;
  localparam int unsigned SH_W  = cnt_width(SMAX + 1);
  localparam int unsigned T_W   = cnt_width(2 * SMAX + 1);
  localparam int unsigned IDX_W = cnt_width(NUM_PAIRS);
  localparam int unsigned P_W   = 2 * DATA_W;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             exact_q, exact_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [T_W-1:0]   t_q, t_d;

  logic                 load_a, load_b, norm_en;
  logic [DATA_W-1:0]    val_a, val_b;
  logic [KEEP_BITS-1:0] trunc_a, trunc_b;
  logic [SH_W-1:0]      sh_a, sh_b;
  logic                 moving_a, moving_b;
  logic [P_W-1:0]       mul_a, mul_b, product;
  logic [T_W-1:0]       t_init;
  logic                 last_pair;

  lead_one_norm #(.DATA_W(DATA_W), .KEEP_BITS(KEEP_BITS)) u_norm_a (
    .clk    (clk),
    .rst    (rst),
    .load   (load_a),
    .en     (norm_en),
    .din    (mem_rd_data),
    .value  (val_a),
    .trunc  (trunc_a),
    .sh     (sh_a),
    .moving (moving_a)
  );

  lead_one_norm #(.DATA_W(DATA_W), .KEEP_BITS(KEEP_BITS)) u_norm_b (
    .clk    (clk),
    .rst    (rst),
    .load   (load_b),
    .en     (norm_en),
    .din    (mem_rd_data),
    .value  (val_b),
    .trunc  (trunc_b),
    .sh     (sh_b),
    .moving (moving_b)
  );

  // One multiplier serves both modes; exact mode feeds the unshifted full operands.
  always_comb begin
    if (exact_q) begin
      mul_a = {{DATA_W{1'b0}}, val_a};
      mul_b = {{DATA_W{1'b0}}, val_b};
    end else begin
      mul_a = {{(P_W - KEEP_BITS){1'b0}}, trunc_a};
      mul_b = {{(P_W - KEEP_BITS){1'b0}}, trunc_b};
    end
  end

  assign product   = mul_a * mul_b;
  assign t_init    = T_W'(2 * SMAX) - T_W'(sh_a) - T_W'(sh_b);
  assign last_pair = (idx_q == IDX_W'(NUM_PAIRS - 1));
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    exact_d     = exact_q;
    p_d         = p_q;
    t_d         = t_q;
    load_a      = 1'b0;
    load_b      = 1'b0;
    norm_en     = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    mem_wr_req  = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: if (start) state_d = StArm;
      StArm: begin
        if (!start) begin
          state_d = StRdA;
          idx_d   = '0;
          exact_d = mode_exact;
        end
      end
      StRdA: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = ADDR_W'({idx_q, 1'b0});
        if (mem_rd_valid) begin
          load_a  = 1'b1;
          state_d = StRdB;
        end
      end
      StRdB: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = ADDR_W'({idx_q, 1'b1});
        if (mem_rd_valid) begin
          load_b  = 1'b1;
          state_d = exact_q ? StMul : StNorm;
        end
      end
      StNorm: begin
        norm_en = 1'b1;
        if (!(moving_a || moving_b)) state_d = StMul;
      end
      StMul: begin
        p_d     = product;
        t_d     = exact_q ? '0 : t_init;
        state_d = (exact_q || t_init == '0) ? StWr : StDenorm;
      end
      StDenorm: begin
        p_d = p_q << 1;
        t_d = t_q - T_W'(1);
        if (t_q == T_W'(1)) state_d = StWr;
      end
      StWr: begin
        mem_wr_req  = 1'b1;
        mem_wr_addr = WR_BASE + ADDR_W'(idx_q);
        mem_wr_data = p_q;
        if (mem_wr_ready) begin
          if (last_pair) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StRdA;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any handshake completing in the same cycle.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      idx_d      = '0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      mem_rd_req = 1'b0;
      mem_wr_req = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      exact_q <= 1'b0;
      p_q     <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exact_q <= exact_d;
      p_q     <= p_d;
      t_q     <= t_d;
    end
  end

endmodule

// File: tb/tb_trunc_mul_seq.sv
// Randomised scoreboard bench for trunc_mul_seq with a latency-configurable RAM model.
module tb_trunc_mul_seq;

  localparam int unsigned DW   = 16;
  localparam int unsigned KB   = 8;
  localparam int unsigned NP   = 8;
  localparam int unsigned AW   = 8;
  localparam int unsigned SMAX = DW - KB;
  localparam logic [AW-1:0] WB = 8'h80;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode_exact = 1'b0;
  logic          abort = 1'b0;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_valid = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic          mem_wr_req;
  logic [AW-1:0] mem_wr_addr;
  logic [2*DW-1:0] mem_wr_data;
  logic          mem_wr_ready = 1'b0;
  logic          busy;
  logic          done;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          rd_lat = 0;
  int          wr_lat = 0;

  trunc_mul_seq #(
    .DATA_W(DW), .KEEP_BITS(KB), .NUM_PAIRS(NP), .ADDR_W(AW), .WR_BASE(WB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode_exact   (mode_exact),
    .abort        (abort),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_req   (mem_wr_req),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .done         (done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Leading zeros, capped at the largest allowed normalisation shift.
  function automatic int lead(input logic [DW-1:0] x);
    int n = 0;
    while (n < int'(SMAX) && x[DW-1-n] == 1'b0) n++;
    return n;
  endfunction

  function automatic logic [31:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input bit exact);
    int unsigned ua, ub, at, bt;
    int sa, sb;
    ua = a;
    ub = b;
    if (exact) return ua * ub;
    sa = lead(a);
    sb = lead(b);
    at = ((ua << sa) & 32'hFFFF) >> (DW - KB);
    bt = ((ub << sb) & 32'hFFFF) >> (DW - KB);
    return (at * bt) << (2 * SMAX - sa - sb);
  endfunction

  initial begin : rd_resp
    int cnt = 0;
    logic [AW-1:0] held = '0;
    bit moved = 0;
    forever begin
      @(negedge clk);
      mem_rd_valid = 1'b0;
      if (mem_rd_req) begin
        if (cnt == 0) begin
          held  = mem_rd_addr;
          moved = 0;
        end else if (mem_rd_addr !== held) begin
          moved = 1;
        end
        if (cnt < rd_lat) begin
          cnt++;
        end else begin
          if (rd_lat > 0) check("rd_addr_stable", {31'b0, moved}, 32'd0);
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem[mem_rd_addr][DW-1:0];
          cnt          = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : wr_resp
    int cnt = 0;
    logic [AW-1:0] held_a = '0;
    logic [2*DW-1:0] held_d = '0;
    bit moved = 0;
    forever begin
      @(negedge clk);
      mem_wr_ready = 1'b0;
      if (mem_wr_req) begin
        if (cnt == 0) begin
          held_a = mem_wr_addr;
          held_d = mem_wr_data;
          moved  = 0;
        end else if (mem_wr_addr !== held_a || mem_wr_data !== held_d) begin
          moved = 1;
        end
        if (cnt < wr_lat) begin
          cnt++;
        end else begin
          if (wr_lat > 0) check("wr_stable", {31'b0, moved}, 32'd0);
          mem_wr_ready = 1'b1;
          cnt          = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // A write is accepted on the next rising edge when req and ready are both high here.
  initial begin : wr_mon
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (mem_wr_req && mem_wr_ready) begin
        mem[mem_wr_addr] = mem_wr_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, required no write",
                   mem_wr_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", {24'b0, mem_wr_addr}, {24'b0, e.addr});
          check("wr_data", mem_wr_data, e.data);
        end
      end
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 2 * int'(NP); i++)
      mem[i] = ($urandom & 32'hFFFF) >> $urandom_range(0, 16);
    for (int i = 0; i < int'(NP); i++) mem[int'(WB) + i] = 32'h0;
  endtask

  // Runs one job; abort_pair < NP aborts in the first DENORM cycle of that pair.
  task automatic run(input bit exact, input int abort_pair);
    logic [DW-1:0] a, b;
    int sa, sb, n, pc, pair_start, abort_cyc, cyc, done_cnt, done_cyc, end_cyc;
    wr_t e;
    exp_q.delete();
    pair_start = 1;
    abort_cyc  = -1;
    for (int i = 0; i < int'(NP); i++) begin
      a  = mem[2*i][DW-1:0];
      b  = mem[2*i+1][DW-1:0];
      sa = lead(a);
      sb = lead(b);
      n  = (sa > sb) ? sa : sb;
      pc = exact ? 4 : (2 + (n + 1) + 1 + (2 * int'(SMAX) - sa - sb) + 1);
      pc += 2 * rd_lat + wr_lat;
      if (i == abort_pair) abort_cyc = pair_start + n + 4;
      if (i < abort_pair) begin
        e.addr = WB + AW'(i);
        e.data = ref_mul(a, b, exact);
        exp_q.push_back(e);
      end
      pair_start += pc;
    end

    mode_exact = exact;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 0;
    done_cnt = 0;
    done_cyc = -1;
    end_cyc  = -1;
    while (cyc < 3000) begin
      abort = (cyc == abort_cyc);
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) begin
        end_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0;

    if (abort_cyc >= 0) begin
      check("abort_idle_cycle", end_cyc, abort_cyc + 1);
      check("abort_no_done", done_cnt, 0);
    end else begin
      check("done_count", done_cnt, 1);
      check("done_cycle", done_cyc, pair_start);
      check("idle_cycle", end_cyc, pair_start + 1);
    end
    repeat (3) @(negedge clk);
    check("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rd_req", {31'b0, mem_rd_req}, 32'd0);
    check("rst_wr_req", {31'b0, mem_wr_req}, 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    rst = 1'b1;

    fill_random();
    mem[0]  = 32'h00FF;
    mem[1]  = 32'h0003;
    mem[2]  = 32'h0000;
    mem[3]  = 32'h1234;
    mem[14] = 32'hFFFF;
    mem[15] = 32'hFFFF;
    run(1'b0, NP);
    check("pair0_result", mem[8'h80], 32'h0000_02FD);
    check("zero_result", mem[8'h81], 32'h0);
    check("ffff_trunc", mem[8'h87], 32'hFE01_0000);

    fill_random();
    mem[14] = 32'hFFFF;
    mem[15] = 32'hFFFF;
    run(1'b1, NP);
    check("ffff_exact", mem[8'h87], 32'hFFFE_0001);

    rd_lat = 3;
    wr_lat = 2;
    fill_random();
    mem[0] = 32'h00FF;
    mem[1] = 32'h0003;
    run(1'b0, NP);
    check("lat_pair0", mem[8'h80], 32'h0000_02FD);
    rd_lat = 0;
    wr_lat = 0;

    fill_random();
    mem[4]     = 32'h8000;
    mem[5]     = 32'h00F0;
    mem[8'h82] = 32'hDEAD_BEEF;
    run(1'b0, 2);
    check("abort_no_wr_82", mem[8'h82], 32'hDEAD_BEEF);

    fill_random();
    run(1'b0, NP);

    for (int r = 0; r < 4; r++) begin
      rd_lat = $urandom_range(0, 2);
      wr_lat = $urandom_range(0, 2);
      fill_random();
      run(r[0], NP);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
